// File: rtl/baccarat_pkg.sv
// rtl/baccarat_pkg.sv - shared types and constants for the baccarat round scoreboard
package baccarat_pkg;

    typedef enum logic [1:0] {
        OUT_NONE   = 2'b00,
        OUT_PLAYER = 2'b01,
        OUT_DEALER = 2'b10,
        OUT_TIE    = 2'b11
    } outcome_t;

    typedef enum logic [1:0] {
        BET_NONE   = 2'b00,
        BET_PLAYER = 2'b01,
        BET_DEALER = 2'b10,
        BET_TIE    = 2'b11
    } bet_side_t;

    typedef enum logic [1:0] {
        SB_IDLE   = 2'b00,
        SB_ARMED  = 2'b01,
        SB_SETTLE = 2'b10,
        SB_HOLD   = 2'b11
    } sb_state_t;

    localparam logic [7:0] BCD_MAX = 8'h99;

endpackage

// File: rtl/bcd_counter2.sv
// rtl/bcd_counter2.sv - two-digit BCD up-counter that saturates at 99
module bcd_counter2
    import baccarat_pkg::*;
(
    input  logic       clk,
    input  logic       resetb,
    input  logic       inc,
    output logic [7:0] count
);

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            count <= 8'h00;
        end else if (inc && count != BCD_MAX) begin
            if (count[3:0] == 4'd9)
                count <= {count[7:4] + 4'd1, 4'h0};
            else
                count <= {count[7:4], count[3:0] + 4'd1};
        end
    end

endmodule

// File: rtl/round_scoreboard.sv
// rtl/round_scoreboard.sv - baccarat round classifier, BCD tallies and wagered balance
// Optional streak outputs under STREAK_TRACK_EN.
module round_scoreboard
    import baccarat_pkg::*;
#(
    parameter int          BAL_W        = 8,
    parameter int unsigned INIT_BALANCE = 100,
    parameter int unsigned TIE_PAYOUT   = 8
) (
    input  logic             slow_clock,
    input  logic             resetb,
    input  logic             new_round,
    input  logic [1:0]       bet_side,
    input  logic [3:0]       bet_amount,
    input  logic             player_win_light,
    input  logic             dealer_win_light,
    output logic [7:0]       pwins_bcd,
    output logic [7:0]       dwins_bcd,
    output logic [7:0]       ties_bcd,
    output logic [BAL_W-1:0] balance,
    output logic [1:0]       last_outcome,
    output logic             settle_pulse,
    output logic             bust
`ifdef STREAK_TRACK_EN
    ,
    output logic [3:0]       streak_len,
    output logic [1:0]       streak_side
`endif
);

    localparam int WIDE = BAL_W + 4;
    localparam logic [WIDE-1:0] BAL_MAX = WIDE'((1 << BAL_W) - 1);

    sb_state_t        state, state_nxt;
    bet_side_t        bet_q;
    logic [3:0]       eff_bet_q;
    outcome_t         outcome_q;
    outcome_t         light_outcome;
    logic             lights_any;
    logic [WIDE-1:0]  gain, loss, bal_wide, sum;
    logic [BAL_W-1:0] settle_bal, bet_ref;
    logic [3:0]       eff_bet_new;

    assign lights_any    = player_win_light | dealer_win_light;
    assign light_outcome = (player_win_light && dealer_win_light) ? OUT_TIE :
                           player_win_light ? OUT_PLAYER : OUT_DEALER;

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) state <= SB_IDLE;
        else         state <= state_nxt;
    end

    // A fresh new_round always wins over lights: an abandoned deal is never charged.
    always_comb begin
        state_nxt = state;
        case (state)
            SB_IDLE:   if (new_round) state_nxt = SB_ARMED;
            SB_ARMED:  if (new_round) state_nxt = SB_ARMED;
                       else if (lights_any) state_nxt = SB_SETTLE;
            SB_SETTLE: state_nxt = new_round ? SB_ARMED : SB_HOLD;
            SB_HOLD:   if (new_round) state_nxt = SB_ARMED;
            default:   state_nxt = SB_IDLE;
        endcase
    end

    always_comb begin
        gain     = '0;
        loss     = '0;
        sum      = '0;
        bal_wide = WIDE'(balance);
        case (bet_q)
            BET_PLAYER: if (outcome_q == OUT_PLAYER) gain = WIDE'(eff_bet_q);
                        else if (outcome_q == OUT_DEALER) loss = WIDE'(eff_bet_q);
            BET_DEALER: if (outcome_q == OUT_DEALER) gain = WIDE'(eff_bet_q);
                        else if (outcome_q == OUT_PLAYER) loss = WIDE'(eff_bet_q);
            BET_TIE:    if (outcome_q == OUT_TIE) gain = WIDE'(TIE_PAYOUT) * WIDE'(eff_bet_q);
                        else loss = WIDE'(eff_bet_q);
            default:    ;
        endcase
        if (loss > bal_wide) begin
            settle_bal = '0;
        end else begin
            sum        = bal_wide + gain - loss;
            settle_bal = (sum > BAL_MAX) ? BAL_MAX[BAL_W-1:0] : sum[BAL_W-1:0];
        end
    end

    // A bet placed in the settle cycle is capped by the balance that settle produces.
    assign bet_ref     = (state == SB_SETTLE) ? settle_bal : balance;
    assign eff_bet_new = (BAL_W'(bet_amount) > bet_ref) ? bet_ref[3:0] : bet_amount;

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            bet_q        <= BET_NONE;
            eff_bet_q    <= 4'd0;
            outcome_q    <= OUT_NONE;
            balance      <= BAL_W'(INIT_BALANCE);
            last_outcome <= 2'b00;
            settle_pulse <= 1'b0;
            bust         <= 1'b0;
        end else begin
            settle_pulse <= (state == SB_SETTLE);
            if (state == SB_SETTLE) begin
                balance      <= settle_bal;
                bust         <= (settle_bal == '0);
                last_outcome <= outcome_q;
            end
            if (new_round) begin
                eff_bet_q <= eff_bet_new;
                bet_q     <= (eff_bet_new == 4'd0) ? BET_NONE : bet_side_t'(bet_side);
            end
            if (state == SB_ARMED && !new_round && lights_any)
                outcome_q <= light_outcome;
        end
    end

    bcd_counter2 u_pwins (
        .clk    (slow_clock),
        .resetb (resetb),
        .inc    (state == SB_SETTLE && outcome_q == OUT_PLAYER),
        .count  (pwins_bcd)
    );

    bcd_counter2 u_dwins (
        .clk    (slow_clock),
        .resetb (resetb),
        .inc    (state == SB_SETTLE && outcome_q == OUT_DEALER),
        .count  (dwins_bcd)
    );

    bcd_counter2 u_ties (
        .clk    (slow_clock),
        .resetb (resetb),
        .inc    (state == SB_SETTLE && outcome_q == OUT_TIE),
        .count  (ties_bcd)
    );

`ifdef STREAK_TRACK_EN
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            streak_len  <= 4'd0;
            streak_side <= 2'b00;
        end else if (state == SB_SETTLE && outcome_q != OUT_TIE && outcome_q != OUT_NONE) begin
            if (streak_side == outcome_q) begin
                if (streak_len != 4'd15) streak_len <= streak_len + 4'd1;
            end else begin
                streak_side <= outcome_q;
                streak_len  <= 4'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_round_scoreboard.sv
// tb/tb_round_scoreboard.sv - scoreboard bench for round_scoreboard with a behavioural model
module tb_round_scoreboard;

    logic       slow_clock;
    logic       resetb;
    logic       new_round;
    logic [1:0] bet_side;
    logic [3:0] bet_amount;
    logic       player_win_light;
    logic       dealer_win_light;
    logic [7:0] pwins_bcd, dwins_bcd, ties_bcd, balance;
    logic [1:0] last_outcome;
    logic       settle_pulse, bust;
`ifdef STREAK_TRACK_EN
    logic [3:0] streak_len;
    logic [1:0] streak_side;
`endif

    round_scoreboard dut (
        .slow_clock       (slow_clock),
        .resetb           (resetb),
        .new_round        (new_round),
        .bet_side         (bet_side),
        .bet_amount       (bet_amount),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light),
        .pwins_bcd        (pwins_bcd),
        .dwins_bcd        (dwins_bcd),
        .ties_bcd         (ties_bcd),
        .balance          (balance),
        .last_outcome     (last_outcome),
        .settle_pulse     (settle_pulse),
        .bust             (bust)
`ifdef STREAK_TRACK_EN
        ,
        .streak_len       (streak_len),
        .streak_side      (streak_side)
`endif
    );

    initial slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    typedef struct {
        logic [7:0] pw, dw, ti, bal;
        logic [1:0] out;
        logic       bust;
    } exp_t;

    exp_t exp_q[$];
    int vectors = 0;
    int miscompares = 0;
    int pulses_seen = 0;
    int exp_pulses = 0;

    int m_bal, m_pw, m_dw, m_ti, m_eff, m_side;

    task automatic chk(input string nm, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int n);
        int s;
        s = (n > 99) ? 99 : n;
        return 8'((s / 10) * 16 + (s % 10));
    endfunction

    task automatic model_reset();
        m_bal = 100; m_pw = 0; m_dw = 0; m_ti = 0; m_eff = 0; m_side = 0;
    endtask

    task automatic model_latch(input int side, input int amt);
        m_eff  = (amt < m_bal) ? amt : m_bal;
        m_side = (m_eff == 0) ? 0 : side;
    endtask

    task automatic model_settle(input bit p, input bit d);
        int   out, delta;
        exp_t e;
        out   = (p && d) ? 3 : (p ? 1 : 2);
        delta = 0;
        if (m_side == 1) delta = (out == 1) ? m_eff : ((out == 2) ? -m_eff : 0);
        if (m_side == 2) delta = (out == 2) ? m_eff : ((out == 1) ? -m_eff : 0);
        if (m_side == 3) delta = (out == 3) ? 8 * m_eff : -m_eff;
        m_bal = m_bal + delta;
        if (m_bal < 0)   m_bal = 0;
        if (m_bal > 255) m_bal = 255;
        if (out == 1) m_pw++;
        if (out == 2) m_dw++;
        if (out == 3) m_ti++;
        e.pw = to_bcd(m_pw); e.dw = to_bcd(m_dw); e.ti = to_bcd(m_ti);
        e.bal = 8'(m_bal); e.out = 2'(out); e.bust = (m_bal == 0);
        exp_q.push_back(e);
        exp_pulses++;
    endtask

    always @(negedge slow_clock) begin
        if (resetb && settle_pulse) begin
            pulses_seen++;
            if (exp_q.size() == 0) begin
                chk("spurious_settle_pulse", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pwins_bcd", pwins_bcd, e.pw);
                chk("dwins_bcd", dwins_bcd, e.dw);
                chk("ties_bcd", ties_bcd, e.ti);
                chk("balance", balance, e.bal);
                chk("last_outcome", last_outcome, e.out);
                chk("bust", bust, e.bust);
            end
        end
    end

    task automatic tick();
        @(posedge slow_clock);
        #1;
    endtask

    task automatic do_round(input int side, input int amt, input bit p, input bit d,
                            input bit abandon, input int side2, input int amt2);
        player_win_light = 1'b0;
        dealer_win_light = 1'b0;
        new_round  = 1'b1;
        bet_side   = 2'(side);
        bet_amount = 4'(amt);
        tick();
        new_round = 1'b0;
        model_latch(side, amt);
        if (abandon) begin
            tick();
            new_round  = 1'b1;
            bet_side   = 2'(side2);
            bet_amount = 4'(amt2);
            tick();
            new_round = 1'b0;
            model_latch(side2, amt2);
        end
        player_win_light = p;
        dealer_win_light = d;
        model_settle(p, d);
        repeat (3) tick();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_pwins"}, pwins_bcd, 0);
        chk({tag, "_dwins"}, dwins_bcd, 0);
        chk({tag, "_ties"}, ties_bcd, 0);
        chk({tag, "_balance"}, balance, 100);
        chk({tag, "_last_outcome"}, last_outcome, 0);
        chk({tag, "_settle_pulse"}, settle_pulse, 0);
        chk({tag, "_bust"}, bust, 0);
    endtask

    task automatic apply_reset(input string tag);
        chk({tag, "_pending_before_reset"}, exp_q.size(), 0);
        chk({tag, "_pulses_before_reset"}, pulses_seen, exp_pulses);
        resetb = 1'b0;
        #1;
        check_reset_values(tag);
        model_reset();
        exp_q.delete();
        pulses_seen = 0;
        exp_pulses  = 0;
        tick();
        tick();
        resetb = 1'b1;
    endtask

    initial begin
        int guard;
        resetb = 1'b0;
        new_round = 1'b0;
        bet_side = 2'b00;
        bet_amount = 4'd0;
        player_win_light = 1'b1;
        dealer_win_light = 1'b1;
        model_reset();
        #12;
        check_reset_values("por");
        tick();
        resetb = 1'b1;

        // lights lit without any deal: nothing may settle
        repeat (6) tick();
        check_reset_values("idle_lights");
        chk("idle_pulses", pulses_seen, 0);

        do_round(1, 5, 1, 0, 0, 0, 0);
        chk("player_win_balance", balance, 105);
        do_round(3, 3, 1, 1, 0, 0, 0);
        chk("tie_bet_balance", balance, 129);
        do_round(1, 7, 1, 1, 0, 0, 0);
        chk("tie_push_balance", balance, 129);

        guard = 0;
        while (m_bal > 4 && guard < 40) begin
            do_round(1, (m_bal - 4 > 15) ? 15 : m_bal - 4, 0, 1, 0, 0, 0);
            guard++;
        end
        chk("drain_to_4", balance, 4);
        do_round(2, 9, 1, 0, 0, 0, 0);
        chk("capped_bet_balance", balance, 0);
        chk("bust_set", bust, 1);
        do_round(1, 5, 1, 0, 0, 0, 0);
        chk("broke_no_change", balance, 0);

        apply_reset("rst_a");
        for (int i = 0; i < 150; i++) begin
            int  lt;
            bit  ab;
            lt = $urandom_range(1, 3);
            ab = ($urandom_range(0, 3) == 0);
            do_round($urandom_range(0, 3), $urandom_range(0, 15), lt[0], lt[1],
                     ab, $urandom_range(0, 3), $urandom_range(0, 15));
        end

        apply_reset("rst_b");
        for (int i = 0; i < 101; i++) begin
            do_round(0, 0, 1, 0, 0, 0, 0);
            if (i == 9) chk("carry_09_10", pwins_bcd, 8'h10);
        end
        chk("pwins_saturated", pwins_bcd, 8'h99);

        // abandon then reset while a bet is pending
        new_round = 1'b1; bet_side = 2'b01; bet_amount = 4'd9;
        tick();
        new_round = 1'b1; bet_side = 2'b10; bet_amount = 4'd15;
        tick();
        new_round = 1'b0;
        apply_reset("rst_mid");
        player_win_light = 1'b1;
        dealer_win_light = 1'b0;
        repeat (5) tick();
        check_reset_values("after_mid_reset");
        chk("after_mid_reset_pulses", pulses_seen, 0);

        chk("final_pending", exp_q.size(), 0);
        chk("final_pulses", pulses_seen, exp_pulses);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
